rtr_vc_route_tracker: RTL

//  Per-input-VC route bookkeeping; sits directly upstream of rtr_route_filter.
//  - Captures the raw lookahead route (output port and resource class) when a

---
 rtl/rtr_vc_route_tracker_pkg.sv | 18 +
 rtl/rtr_route_store.sv | 61 ++++++
 rtl/rtr_vc_route_tracker.sv | 102 ++++++++++
 3 files changed

// File: rtl/rtr_vc_route_tracker_pkg.sv
// Shared helpers and types for the per-VC route tracker slice.
package rtr_vc_route_tracker_pkg;

  typedef enum logic [0:0] {
    ARR_IDLE = 1'b0,
    ARR_BODY = 1'b1
  } arr_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rtr_route_store.sv
// Register-file FIFO holding one route per buffered packet, with pointers,
// occupancy count and full/empty flags.
module rtr_route_store
  import rtr_vc_route_tracker_pkg::*;
#(
  parameter int unsigned depth = 4,
  parameter int unsigned width = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] wr_data,
  output logic [width-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  // A single-entry store still needs a 1-bit pointer to index the array.
  localparam int unsigned ptr_w = (clog2(depth) > 0) ? clog2(depth) : 1;
  localparam int unsigned cnt_w = clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] rd_ptr;
  logic [ptr_w-1:0] wr_ptr;
  logic [cnt_w-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(depth - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  assign full    = (count == cnt_w'(depth));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // On a full store a simultaneous pop frees the slot the push lands in.
  assign push_ok = push & (~full | pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rtr_vc_route_tracker.sv
// Per-input-VC route bookkeeping: captures lookahead routes on head arrival,
// presents the oldest packet's route, retires it on tail departure.
module rtr_vc_route_tracker
  import rtr_vc_route_tracker_pkg::*;
#(
  parameter int unsigned num_resource_classes = 2,
  parameter int unsigned num_ports            = 5,
  parameter int unsigned max_packets          = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flit_valid,
  input  logic                            flit_head,
  input  logic                            flit_tail,
  input  logic [num_ports-1:0]            route_in_op,
  input  logic [num_resource_classes-1:0] route_in_orc,
  input  logic                            flit_sent,
  input  logic                            flit_sent_tail,
  output logic                            route_valid,
  output logic [num_ports-1:0]            route_op,
  output logic [num_resource_classes-1:0] route_orc,
  output logic [2:0]                      errors
);

  localparam int unsigned entry_w = num_ports + num_resource_classes;

  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [entry_w-1:0] rd_data;
  logic               overflow;
  logic               underflow;
  logic               framing;
  arr_state_t         state;
  arr_state_t         state_nxt;

  assign push = flit_valid & flit_head;
  assign pop  = flit_sent & flit_sent_tail;

  rtr_route_store #(
    .depth (max_packets),
    .width (entry_w)
  ) u_store (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data ({route_in_op, route_in_orc}),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  assign route_valid = ~empty;

  always_comb begin
    route_op  = '0;
    route_orc = '0;
    if (!empty) begin
      route_op  = rd_data[entry_w-1:num_resource_classes];
      route_orc = rd_data[num_resource_classes-1:0];
    end
  end

  assign overflow  = push & full & ~pop;
  assign underflow = pop & empty;

  // A head always restarts framing from its own tail bit, even mid-packet.
  always_comb begin
    state_nxt = state;
    framing   = 1'b0;
    if (flit_valid) begin
      case (state)
        ARR_IDLE: begin
          if (flit_head) state_nxt = flit_tail ? ARR_IDLE : ARR_BODY;
          else           framing   = 1'b1;
        end
        ARR_BODY: begin
          if (flit_head) begin
            framing   = 1'b1;
            state_nxt = flit_tail ? ARR_IDLE : ARR_BODY;
          end else if (flit_tail) begin
            state_nxt = ARR_IDLE;
          end
        end
        default: state_nxt = ARR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ARR_IDLE;
      errors <= '0;
    end else begin
      state  <= state_nxt;
      errors <= {framing, underflow, overflow};
    end
  end

endmodule
